second_back_counter: RTL and testbench

// - Seconds down-counter for the traffic-light controller.
// - Loads a phase duration selected by mode, then decrements once per one-second pulse.
// - Flags timeout when the count expires, then reloads automatically.
// - Sits between the 1 Hz tick generator and the light-sequencing FSM.
//   The FSM consumes timeout; the display path consumes sec_count.

---
 rtl/second_back_counter.sv | 110 +++++++++++
 tb/tb_second_back_counter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/second_back_counter.sv
`default_nettype none
// ============================================================================
// Module      : second_back_counter
// Description : Seconds down-counter for the traffic-light controller. Loads
//               a phase duration selected by mode, decrements once per
//               one-second pulse, strobes timeout when the count reaches 0
//               and reloads automatically.
//               Optional feature macro: SECOND_BACK_COUNTER_MODE_RESTART_EN
//               (when defined, a mode change during COUNT restarts the load).
// Revision    : 1.0 - initial release
// ============================================================================
module second_back_counter #(
    parameter int unsigned T_MODE1 = 30,   // load value when mode=1 (1..63)
    parameter int unsigned T_MODE0 = 5     // load value when mode=0 (1..63)
) (
    input  logic       clk,
    input  logic       rst_n,              // synchronous, active-high despite the name
    input  logic       mode,
    input  logic       pulse,
    output logic       timeout,
    output logic [5:0] sec_count
);

    localparam logic [5:0] c_load_mode1 = 6'(T_MODE1);
    localparam logic [5:0] c_load_mode0 = 6'(T_MODE0);

    typedef enum logic [0:0] {
        S_LOAD  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic       timeout_q, timeout_d;

`ifdef SECOND_BACK_COUNTER_MODE_RESTART_EN
    logic       mode_q, mode_d;
    logic       w_mode_changed;

    // Registered copy of mode; a mismatch in COUNT means the duration changed.
    assign mode_d         = mode;
    assign w_mode_changed = (mode != mode_q);

    // Mode copy register; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    logic       w_mode_changed;

    // Mid-count mode changes are ignored; mode is only looked at in LOAD.
    assign w_mode_changed = 1'b0;
`endif

    // Next-state and next-output computation for the LOAD/COUNT sequencer.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timeout_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                // pulse is ignored while loading
                count_d = mode ? c_load_mode1 : c_load_mode0;
                state_d = S_COUNT;
            end
            S_COUNT: begin
                if (w_mode_changed) begin
                    // restart with the new duration: no decrement, no timeout
                    state_d = S_LOAD;
                end else if (count_q == 6'd0) begin
                    // only reachable with an illegal zero load value
                    state_d = S_LOAD;
                end else if (pulse) begin
                    if (count_q == 6'd1) begin
                        count_d   = 6'd0;
                        timeout_d = 1'b1;
                        state_d   = S_LOAD;
                    end else begin
                        count_d = count_q - 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State, count and timeout registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_LOAD;
            count_q   <= 6'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout   = timeout_q;
    assign sec_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_second_back_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_second_back_counter
// Description : Scoreboard bench for second_back_counter. The driver applies
//               directed and random stimulus on the falling edge, advances a
//               behavioural model and queues the expected outputs; a monitor
//               pops and compares one entry after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_second_back_counter;

    localparam int c_t1 = 30;
    localparam int c_t0 = 5;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       pulse;
    logic       timeout;
    logic [5:0] sec_count;

    typedef struct {
        int cnt;
        bit to;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests;
    int   n_fail;

    // model state: remaining seconds, whether the next edge reloads,
    // and the last non-reset mode seen (used by the restart feature)
    int m_cnt;
    bit m_reload;
    bit m_to;
    bit m_last_mode;

    second_back_counter #(
        .T_MODE1(c_t1),
        .T_MODE0(c_t0)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .pulse    (pulse),
        .timeout  (timeout),
        .sec_count(sec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model by one clock with the given inputs.
    task automatic model_step(input bit r, input bit m, input bit p);
        bit restart;
`ifdef SECOND_BACK_COUNTER_MODE_RESTART_EN
        restart = (m != m_last_mode);
`else
        restart = 1'b0;
`endif
        m_to = 1'b0;
        if (r) begin
            m_cnt       = 0;
            m_reload    = 1'b1;
            m_last_mode = 1'b0;
            return;
        end
        if (m_reload) begin
            m_cnt    = m ? c_t1 : c_t0;
            m_reload = 1'b0;
        end else if (restart || m_cnt == 0) begin
            m_reload = 1'b1;
        end else if (p) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_to     = 1'b1;
                m_reload = 1'b1;
            end
        end
        m_last_mode = m;
    endtask

    // Drive one cycle of stimulus and queue the expected outcome.
    task automatic cyc(input bit r, input bit m, input bit p);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        mode  = m;
        pulse = p;
        model_step(r, m, p);
        e.cnt = m_cnt;
        e.to  = m_to;
        q_exp.push_back(e);
    endtask

    // Monitor: compare DUT outputs just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            n_tests++;
            if (int'(sec_count) != e.cnt || timeout !== e.to) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t: got sec_count=%0d timeout=%b, expected sec_count=%0d timeout=%b",
                         $time, sec_count, timeout, e.cnt, e.to);
            end
        end
    end

    initial begin
        int guard;
        n_tests     = 0;
        n_fail      = 0;
        m_cnt       = 0;
        m_reload    = 1'b1;
        m_to        = 1'b0;
        m_last_mode = 1'b0;
        rst_n       = 1'b1;
        mode        = 1'b0;
        pulse       = 1'b0;

        // reset for two clocks, then mode 0 with pulse held high
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        for (int i = 0; i < 14; i++) cyc(0, 0, 1);

        // mode 1 with pulse held: two full periods of 31
        cyc(1, 1, 0);
        for (int i = 0; i < 64; i++) cyc(0, 1, 1);

        // mode 0, pulse 1 clk high / 3 clk low
        cyc(1, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0, (i % 4) == 0);

        // reset while counting in mode 1 at sec_count=17
        cyc(1, 1, 0);
        guard = 0;
        while (!(m_cnt == 17 && !m_reload) && guard < 100) begin
            cyc(0, 1, 1);
            guard++;
        end
        cyc(1, 1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1);

        // mode 1 -> 0 at sec_count=20
        cyc(1, 1, 0);
        guard = 0;
        while (!(m_cnt == 20 && !m_reload) && guard < 100) begin
            cyc(0, 1, 1);
            guard++;
        end
        for (int i = 0; i < 30; i++) cyc(0, 0, 1);

        // random traffic with occasional resets and mode flips
        for (int i = 0; i < 3000; i++) begin
            bit r, m, p;
            r = ($urandom_range(0, 199) == 0);
            m = ($urandom_range(0, 49) == 0) ? ~mode : mode;
            p = ($urandom_range(0, 3) != 0);
            cyc(r, m, p);
        end

        // drain the scoreboard
        repeat (3) @(negedge clk);
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
